// File: rtl/cp0.sv
// cp0: coprocessor 0 exception/interrupt control; optional hardware interrupts via CP0_HWINT_EN
module cp0 (
   input  logic        clk,
   input  logic        rst,
   input  logic        exc_req,
   input  logic [2:0]  exc_cause,
   input  logic [31:0] exc_pc,
   input  logic        eret,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata,
   input  logic [4:0]  raddr,
`ifdef CP0_HWINT_EN
   input  logic [5:0]  hw_int,
`endif
   output logic [31:0] rdata,
   output logic        redirect,
   output logic [31:0] redirect_pc,
   output logic        exl
);
   localparam logic [31:0] VEC  = 32'h8000_0180;
   localparam logic [31:0] PRID = 32'h0001_8000;

   typedef enum logic {NORMAL = 1'b0, HANDLER = 1'b1} state_e;

   state_e      state_q, state_d;
   logic        ie_q, ie_d;
   logic [4:0]  code_q, code_d;
   logic [31:0] epc_q, epc_d;
   logic        redir_q, redir_d;
   logic [31:0] rpc_q, rpc_d;
   logic        pend_q, pend_d;
   logic [31:0] ppc_q, ppc_d;
   logic [5:0]  im_q, ip_q;
   logic        exc_v, irq, take, ret, ev, wr_st, wr_ep;
   logic [31:0] tgt;

`ifdef CP0_HWINT_EN
   logic [5:0] im_d;
   // interrupt mask and sampled pending lines
   always_ff @(posedge clk) begin
      if (rst) begin
         im_q <= '0;
         ip_q <= '0;
      end else begin
         im_q <= im_d;
         ip_q <= hw_int;
      end
   end
`else
   assign im_q = '0;
   assign ip_q = '0;
`endif

   // architectural state and redirect pulse registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= NORMAL;
         ie_q    <= 1'b0;
         code_q  <= '0;
         epc_q   <= '0;
         redir_q <= 1'b0;
         rpc_q   <= '0;
         pend_q  <= 1'b0;
         ppc_q   <= '0;
      end else begin
         state_q <= state_d;
         ie_q    <= ie_d;
         code_q  <= code_d;
         epc_q   <= epc_d;
         redir_q <= redir_d;
         rpc_q   <= rpc_d;
         pend_q  <= pend_d;
         ppc_q   <= ppc_d;
      end
   end

   // event decode, next state, register writes and redirect spacing
   always_comb begin
      exc_v   = exc_req && exc_cause != 3'd0 && exc_cause <= 3'd3;
      irq     = state_q == NORMAL && ie_q && |(ip_q & im_q) && !exc_v;
      take    = exc_v || irq;
      ret     = eret && state_q == HANDLER && !take;
      ev      = take || ret;
      tgt     = take ? VEC : epc_q;
      wr_st   = we && waddr == 5'd12 && !take;
      wr_ep   = we && waddr == 5'd14 && !take;
      state_d = wr_st ? state_e'(wdata[1]) : state_q;
      ie_d    = wr_st ? wdata[0] : ie_q;
      epc_d   = wr_ep ? wdata : epc_q;
      code_d  = code_q;
`ifdef CP0_HWINT_EN
      im_d    = wr_st ? wdata[15:10] : im_q;
`endif
      if (take) begin
         state_d = HANDLER;
         code_d  = irq ? 5'd0 : (exc_cause == 3'd1 ? 5'd10 : 5'd12);
         epc_d   = state_q == NORMAL ? exc_pc : epc_q;
      end else if (ret) begin
         state_d = NORMAL;
      end
      redir_d = 1'b0;
      rpc_d   = rpc_q;
      pend_d  = pend_q;
      ppc_d   = ppc_q;
      if (redir_q) begin
         pend_d = ev;
         ppc_d  = tgt;
      end else if (ev || pend_q) begin
         redir_d = 1'b1;
         rpc_d   = ev ? tgt : ppc_q;
         pend_d  = 1'b0;
      end
   end

   // mfc0 read port shows pre-edge register values
   always_comb begin
      rdata = raddr == 5'd12 ? {16'b0, im_q, 8'b0, state_q == HANDLER, ie_q} :
              raddr == 5'd13 ? {16'b0, ip_q, 3'b0, code_q, 2'b0} :
              raddr == 5'd14 ? epc_q :
              raddr == 5'd15 ? PRID : 32'h0;
   end

   assign redirect    = redir_q;
   assign redirect_pc = rpc_q;
   assign exl         = state_q == HANDLER;
endmodule

// File: doc/cp0.md
CP0 -- requirements
Module: cp0

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have port exc_req, input, 1 bit: the pipeline raises an exception this cycle.
REQ-004 SHALL have port exc_cause, input, 3 bits: 001 undefined instruction, 010 add overflow, 011 sub overflow.
REQ-005 SHALL have port exc_pc, input, 32 bits: PC of the faulting or resumable instruction, valid every cycle.
REQ-006 SHALL have port eret, input, 1 bit: return-from-exception request.
REQ-007 SHALL have ports we (input, 1 bit), waddr (input, 5 bits) and wdata (input, 32 bits): mtc0 write.
REQ-008 SHALL have ports raddr (input, 5 bits) and rdata (output, 32 bits): mfc0 read, combinational.
REQ-009 SHALL have port redirect, output, 1 bit: one-cycle pulse that loads redirect_pc and flushes IF/ID/EX.
REQ-010 SHALL have port redirect_pc, output, 32 bits: target of the redirect.
REQ-011 SHALL have port exl, output, 1 bit: the handler is active (Status.EXL).

Function
REQ-012 SHALL implement these registers:
- Status (12): IE bit0, EXL bit1, IM[15:10].
- Cause (13): ExcCode[6:2], IP[15:10].
- EPC (14).
- PRId (15): constant 0x0001_8000.
REQ-013 SHALL return 0 on rdata for any other raddr; reads SHALL show pre-edge values, so a same-cycle write is not visible.
REQ-014 SHALL use a two-state FSM, NORMAL (EXL=0) and HANDLER (EXL=1); exl SHALL equal the state.
REQ-015 SHALL, on exc_req=1 with exc_cause in {001,010,011}, sampled at edge N while in NORMAL:
- EPC <= exc_pc;
- ExcCode <= 10 for 001, 12 for 010/011;
- EXL <= 1, go to HANDLER;
- redirect=1 and redirect_pc=0x8000_0180 during cycle N+1 only.
REQ-016 SHALL treat exc_req with any other exc_cause value as no request.
REQ-017 SHALL, on exc_req in HANDLER, update ExcCode, keep EPC unchanged, and issue the redirect to 0x8000_0180 as in REQ-015.
REQ-018 SHALL, on eret in HANDLER, clear EXL, go to NORMAL, and assert redirect=1 with redirect_pc=EPC in the next cycle.
REQ-019 SHALL ignore eret in NORMAL: no redirect, no state change.
REQ-020 SHALL give exc_req priority over eret when both are asserted in the same cycle.
REQ-021 SHALL give an exception priority over an mtc0 write to Status, Cause or EPC in the same cycle; the write SHALL be dropped.
REQ-022 SHALL accept mtc0 writes to Status IE/EXL/IM and to EPC; ExcCode, IP and PRId SHALL be read-only.
REQ-023 SHALL hold redirect_pc at its last value while redirect=0.
REQ-024 SHALL NOT assert redirect in two consecutive cycles; a new event in the pulse cycle SHALL produce a second pulse after one idle cycle.

Reset
REQ-025 SHALL, on rst=1 at a clock edge, clear Status, Cause and EPC, drive redirect=0 and redirect_pc=0, and enter NORMAL.
REQ-026 SHALL, on reset during HANDLER or during a redirect pulse, abort with no further redirect.
REQ-027 SHALL give rst priority over every other input.

Configuration
REQ-028 SHALL support macro CP0_HWINT_EN.
REQ-029 SHALL, with CP0_HWINT_EN defined:
- add input hw_int[5:0];
- register IP <= hw_int every cycle;
- in NORMAL with IE=1 and |(IP & IM) and no exc_req, take an interrupt with ExcCode=0, EPC <= exc_pc, and the same redirect timing as REQ-015.
REQ-030 SHALL, without CP0_HWINT_EN, have no hw_int port, read IP and IM as 0, and ignore writes to IM.

Verification
REQ-031 SHALL cover: reset, then exc_req with cause 010 and exc_pc=0x0000_3010 -> next cycle redirect=1, redirect_pc=0x8000_0180; EPC=0x0000_3010; Cause=0x0000_0030; exl=1.
REQ-032 SHALL cover: from REQ-031, eret -> next cycle redirect=1, redirect_pc=0x0000_3010; exl=0; the cycle after, redirect=0.
REQ-033 SHALL cover: in HANDLER, exc_req with cause 001 and exc_pc=0x0000_3020 -> redirect to 0x8000_0180; EPC still 0x0000_3010; ExcCode=10.
REQ-034 SHALL cover: exc_req and eret together in NORMAL -> exception taken; and exc_req with cause 000 -> no redirect, no state change.
REQ-035 SHALL cover: mtc0 EPC=0x1234 in the same cycle as exc_req (exc_pc=0x40) -> EPC=0x40; and rst asserted in HANDLER -> exl=0, redirect=0, all registers 0.
REQ-036 SHALL cover, with CP0_HWINT_EN: Status=0x0000_0401 and hw_int=000001 -> interrupt taken with ExcCode=0 and redirect to 0x8000_0180; with IE=0, no redirect.
